// File: rtl/microseq_pkg.sv
// microseq_pkg: shared types and helpers for the microprogram sequencer.
//   - seq_op_e / cond_e : sequencing operation and branch condition encodings
//   - field offset helpers for the microword layout
//       MSB..LSB : ctrl[CTRL_W] | seq_op[3] | cond[2] | target[UA_W]
//   - decode_seq        : splits the 5-bit seq_op/cond field
//   - cond_true         : evaluates a branch condition against {C,N,Z}
package microseq_pkg;

    typedef enum logic [2:0] {
        SEQ_NEXT     = 3'b000,
        SEQ_JUMP     = 3'b001,
        SEQ_JCOND    = 3'b010,
        SEQ_DISPATCH = 3'b011,
        SEQ_CALL     = 3'b100,
        SEQ_RET      = 3'b101,
        SEQ_FETCH    = 3'b110,
        SEQ_HALT     = 3'b111
    } seq_op_e;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_Z      = 2'b01,
        COND_N      = 2'b10,
        COND_C      = 2'b11
    } cond_e;

    typedef struct packed {
        seq_op_e seq_op;
        cond_e   cond;
    } seq_fields_t;

    localparam int SEQ_W  = 3;
    localparam int COND_W = 2;
    localparam int SC_W   = SEQ_W + COND_W;

    // Bit positions inside the flags input {C,N,Z}.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    function automatic int cond_lsb(input int ua_w);
        return ua_w;
    endfunction

    function automatic int seq_lsb(input int ua_w);
        return ua_w + COND_W;
    endfunction

    function automatic int ctrl_lsb(input int ua_w);
        return ua_w + SC_W;
    endfunction

    function automatic int uw_width(input int ctrl_w, input int ua_w);
        return ctrl_w + SC_W + ua_w;
    endfunction

    function automatic seq_fields_t decode_seq(input logic [SC_W-1:0] sc);
        seq_fields_t f;
        f.seq_op = seq_op_e'(sc[SC_W-1:COND_W]);
        f.cond   = cond_e'(sc[COND_W-1:0]);
        return f;
    endfunction

    function automatic logic cond_true(input cond_e c, input logic [2:0] flags);
        logic r;
        case (c)
            COND_Z:  r = flags[FLAG_Z];
            COND_N:  r = flags[FLAG_N];
            COND_C:  r = flags[FLAG_C];
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/microseq_stack.sv
// microseq_stack: DEPTH x W LIFO holding micro-return addresses.
//   clk, reset : clock, asynchronous active-high reset (empties the stack)
//   push, din  : push din when not full
//   pop        : drop the top entry when not empty
//   dout       : current top entry (valid only when empty=0)
//   full/empty : occupancy flags
// Callers are expected to gate push/pop with full/empty; illegal requests
// are ignored here as a second line of defence.
module microseq_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage rounded up to a power of two so the index never overruns.
    logic [W-1:0]    mem [2**IDX_W];
    logic [SP_W-1:0] sp_q, sp_d;
    logic [SP_W-1:0] sp_m1;
    logic            do_push, do_pop;

    assign full    = (sp_q == SP_W'(DEPTH));
    assign empty   = (sp_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;
    assign sp_m1   = sp_q - SP_W'(1);
    assign dout    = mem[sp_m1[IDX_W-1:0]];

    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + SP_W'(1);
        end else if (do_pop) begin
            sp_d = sp_m1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[sp_q[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/microseq_ctrl.sv
// microseq_ctrl: microprogram sequencer with a writable control store.
//   clk, reset      : clock, asynchronous active-high reset
//   run             : advance enable (0 = stall, emit bubble)
//   opcode          : macro opcode used by DISPATCH
//   flags           : {C,N,Z} used by JCOND
//   ld_we/addr/data : control-store write port (always active)
//   ctrl            : registered control word
//   upc             : current micro-PC
//   halted          : sticky, set by a HALT word
//   stack_err       : sticky, set by CALL on full / RET on empty
// Each advance cycle reads store[upc] combinationally, registers its ctrl
// field and loads the next micro-address selected by its seq_op.
module microseq_ctrl
    import microseq_pkg::*;
#(
    parameter int UA_W        = 8,
    parameter int CTRL_W      = 29,
    parameter int OP_W        = 5,
    parameter int SLOT_LOG2   = 3,
    parameter int STACK_DEPTH = 4,
    localparam int UW_W       = CTRL_W + 5 + UA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [OP_W-1:0]   opcode,
    input  logic [2:0]        flags,
    input  logic              ld_we,
    input  logic [UA_W-1:0]   ld_addr,
    input  logic [UW_W-1:0]   ld_data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [UA_W-1:0]   upc,
    output logic              halted,
    output logic              stack_err
);

    localparam int CTRL_LSB = ctrl_lsb(UA_W);
    localparam int STORE_N  = 1 << UA_W;

    if (OP_W + SLOT_LOG2 != UA_W) begin : g_bad_dispatch_width
        $error("microseq_ctrl: OP_W + SLOT_LOG2 must equal UA_W");
    end
    if (STACK_DEPTH < 1) begin : g_bad_stack_depth
        $error("microseq_ctrl: STACK_DEPTH must be at least 1");
    end
    if (uw_width(CTRL_W, UA_W) != UW_W) begin : g_bad_word_width
        $error("microseq_ctrl: microword width inconsistent with package layout");
    end

    // Control store: no reset, contents survive reset.
    logic [UW_W-1:0] store_mem [STORE_N];

    always_ff @(posedge clk) begin
        if (ld_we) begin
            store_mem[ld_addr] <= ld_data;
        end
    end

    logic [UA_W-1:0]   upc_q, upc_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              halted_q, halted_d;
    logic              stack_err_q, stack_err_d;

    // Current microword, split into its fields. The read happens before the
    // edge, so a same-cycle load to store[upc] is only seen next cycle.
    logic [UW_W-1:0]   cur_word;
    logic [CTRL_W-1:0] w_ctrl;
    logic [SC_W-1:0]   w_sc;
    logic [UA_W-1:0]   w_target;
    seq_fields_t       w_f;

    assign cur_word = store_mem[upc_q];
    assign w_ctrl   = cur_word[UW_W-1:CTRL_LSB];
    assign w_sc     = cur_word[CTRL_LSB-1:UA_W];
    assign w_target = cur_word[UA_W-1:0];
    assign w_f      = decode_seq(w_sc);

    logic [UA_W-1:0] upc_inc;
    logic [UA_W-1:0] dispatch_addr;

    assign upc_inc       = upc_q + UA_W'(1);   // wraps at the top address
    assign dispatch_addr = {opcode, {SLOT_LOG2{1'b0}}};

    logic            stk_push, stk_pop, stk_full, stk_empty;
    logic [UA_W-1:0] stk_dout;

    microseq_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (UA_W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (upc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        upc_d       = upc_q;
        ctrl_d      = '0;
        halted_d    = halted_q;
        stack_err_d = stack_err_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;

        if (run && !halted_q) begin
            ctrl_d = w_ctrl;
            case (w_f.seq_op)
                SEQ_NEXT:     upc_d = upc_inc;
                SEQ_JUMP:     upc_d = w_target;
                SEQ_JCOND:    upc_d = cond_true(w_f.cond, flags) ? w_target : upc_inc;
                SEQ_DISPATCH: upc_d = dispatch_addr;
                SEQ_CALL: begin
                    if (stk_full) begin
                        upc_d       = '0;
                        stack_err_d = 1'b1;
                    end else begin
                        stk_push = 1'b1;
                        upc_d    = w_target;
                    end
                end
                SEQ_RET: begin
                    if (stk_empty) begin
                        upc_d       = '0;
                        stack_err_d = 1'b1;
                    end else begin
                        stk_pop = 1'b1;
                        upc_d   = stk_dout;
                    end
                end
                SEQ_FETCH:    upc_d = '0;
                SEQ_HALT:     halted_d = 1'b1;   // upc holds on the HALT word
                default:      upc_d = upc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upc_q       <= '0;
            ctrl_q      <= '0;
            halted_q    <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            upc_q       <= upc_d;
            ctrl_q      <= ctrl_d;
            halted_q    <= halted_d;
            stack_err_q <= stack_err_d;
        end
    end

    assign upc       = upc_q;
    assign ctrl      = ctrl_q;
    assign halted    = halted_q;
    assign stack_err = stack_err_q;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Testbench for microseq_ctrl: directed scenarios followed by a randomized
// run, every cycle compared against a behavioural model of the sequencer.
module tb_microseq_ctrl;

    localparam int UA_W   = 8;
    localparam int CTRL_W = 29;
    localparam int OP_W   = 5;
    localparam int UW_W   = CTRL_W + 5 + UA_W;
    localparam int DEPTH  = 4;

    localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, JCOND = 3'd2, DISP = 3'd3,
                           CALL = 3'd4, RET = 3'd5, FETCH = 3'd6, HALT = 3'd7;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              run = 1'b0;
    logic [OP_W-1:0]   opcode = '0;
    logic [2:0]        flags = '0;
    logic              ld_we = 1'b0;
    logic [UA_W-1:0]   ld_addr = '0;
    logic [UW_W-1:0]   ld_data = '0;
    logic [CTRL_W-1:0] ctrl;
    logic [UA_W-1:0]   upc;
    logic              halted;
    logic              stack_err;

    always #5 clk = ~clk;

    microseq_ctrl #(
        .UA_W(UA_W), .CTRL_W(CTRL_W), .OP_W(OP_W), .SLOT_LOG2(3), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .flags(flags),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .ctrl(ctrl), .upc(upc), .halted(halted), .stack_err(stack_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [UW_W-1:0]   m_store [256];
    int                m_upc;
    logic [CTRL_W-1:0] m_ctrl;
    bit                m_halt;
    bit                m_err;
    int                m_stack[$];

    function automatic logic [UW_W-1:0] mk(input logic [CTRL_W-1:0] c, input logic [2:0] s,
                                           input logic [1:0] cd, input logic [7:0] t);
        return {c, s, cd, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".upc"}, 32'(upc), 32'(m_upc));
        chk({tag, ".ctrl"}, 32'(ctrl), 32'(m_ctrl));
        chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
        chk({tag, ".stack_err"}, 32'(stack_err), 32'(m_err));
    endtask

    // One clock edge of the sequencer as described by its rules.
    task automatic model_edge();
        logic [UW_W-1:0] w;
        logic [2:0] s;
        logic [1:0] cd;
        int t, nxt;
        bit take;
        if (run && !m_halt) begin
            w   = m_store[m_upc];
            s   = w[12:10];
            cd  = w[9:8];
            t   = int'(w[7:0]);
            nxt = (m_upc + 1) % 256;
            m_ctrl = w[UW_W-1:13];
            case (s)
                NEXT:  m_upc = nxt;
                JUMP:  m_upc = t;
                JCOND: begin
                    take = (cd == 2'd0) || (cd == 2'd1 && flags[0]) ||
                           (cd == 2'd2 && flags[1]) || (cd == 2'd3 && flags[2]);
                    m_upc = take ? t : nxt;
                end
                DISP:  m_upc = int'(opcode) * 8;
                CALL: begin
                    if (m_stack.size() >= DEPTH) begin
                        m_upc = 0;
                        m_err = 1'b1;
                    end else begin
                        m_stack.push_back(nxt);
                        m_upc = t;
                    end
                end
                RET: begin
                    if (m_stack.size() == 0) begin
                        m_upc = 0;
                        m_err = 1'b1;
                    end else begin
                        m_upc = m_stack.pop_back();
                    end
                end
                FETCH: m_upc = 0;
                default: m_halt = 1'b1;
            endcase
        end else begin
            m_ctrl = '0;
        end
        if (ld_we) m_store[ld_addr] = ld_data;
    endtask

    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        m_upc  = 0;
        m_ctrl = '0;
        m_halt = 1'b0;
        m_err  = 1'b0;
        m_stack.delete();
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [UW_W-1:0] d);
        run     = 1'b0;
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        cyc("load");
        ld_we   = 1'b0;
    endtask

    function automatic logic [UW_W-1:0] rand_word();
        int p;
        logic [2:0] s;
        p = $urandom_range(0, 99);
        if (p < 30)      s = NEXT;
        else if (p < 45) s = JUMP;
        else if (p < 60) s = JCOND;
        else if (p < 70) s = DISP;
        else if (p < 80) s = CALL;
        else if (p < 90) s = RET;
        else if (p < 98) s = FETCH;
        else             s = HALT;
        return mk(29'($urandom), s, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    endfunction

    initial begin
        #1;
        do_reset();

        // Alternating NEXT / FETCH loop.
        load(8'h00, mk(29'd1, NEXT, 2'd0, 8'h00));
        load(8'h01, mk(29'd2, FETCH, 2'd0, 8'h00));
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc("loop");
            chk("loop_ctrl", 32'(ctrl), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("loop_upc", 32'(upc), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Same-cycle load to the current address: old word is used.
        load(8'h00, mk(29'd1, NEXT, 2'd0, 8'h00));
        run = 1'b1; ld_we = 1'b1; ld_addr = 8'h00; ld_data = mk(29'd9, JUMP, 2'd0, 8'h55);
        cyc("ld_same");
        ld_we = 1'b0;
        chk("ld_same_ctrl", 32'(ctrl), 32'd2 - 32'd1);
        chk("ld_same_upc", 32'(upc), 32'd1);
        cyc("ld_same2");    // word 1 is FETCH -> upc 0
        cyc("ld_new");      // new word at 0 now executes
        chk("ld_new_ctrl", 32'(ctrl), 32'd9);
        chk("ld_new_upc", 32'(upc), 32'h55);

        // DISPATCH.
        do_reset();
        load(8'h00, mk(29'd0, DISP, 2'd0, 8'h00));
        load(8'h18, mk(29'h18AB, NEXT, 2'd0, 8'h00));
        opcode = 5'h03; run = 1'b1;
        cyc("disp");
        chk("disp_upc", 32'(upc), 32'h18);
        cyc("disp2");
        chk("disp_ctrl", 32'(ctrl), 32'h18AB);

        // JCOND on Z, taken and not taken.
        do_reset();
        load(8'h00, mk(29'd5, JUMP, 2'd0, 8'h10));
        load(8'h10, mk(29'd7, JCOND, 2'd1, 8'h40));
        run = 1'b1;
        cyc("jc_a");
        flags = 3'b001;
        cyc("jc_taken");
        chk("jc_taken_upc", 32'(upc), 32'h40);
        do_reset();
        run = 1'b1; flags = 3'b000;
        cyc("jc_b");
        flags = 3'b110;
        cyc("jc_not");
        chk("jc_not_upc", 32'(upc), 32'h11);

        // CALL / RET.
        do_reset();
        load(8'h00, mk(29'd1, JUMP, 2'd0, 8'h20));
        load(8'h20, mk(29'd2, CALL, 2'd0, 8'h70));
        load(8'h70, mk(29'd3, RET, 2'd0, 8'h00));
        run = 1'b1;
        cyc("call0");
        cyc("call");
        chk("call_upc", 32'(upc), 32'h70);
        cyc("ret");
        chk("ret_upc", 32'(upc), 32'h21);

        // CALL at the top address pushes 0 (wrap).
        do_reset();
        load(8'h00, mk(29'd1, JUMP, 2'd0, 8'hFF));
        load(8'hFF, mk(29'd2, CALL, 2'd0, 8'h05));
        load(8'h05, mk(29'd3, RET, 2'd0, 8'h00));
        run = 1'b1;
        cyc("wrap0"); cyc("wrap1"); cyc("wrap_ret");
        chk("wrap_ret_upc", 32'(upc), 32'h00);

        // Stack overflow on the fifth nested CALL.
        do_reset();
        load(8'h00, mk(29'd10, CALL, 2'd0, 8'h30));
        for (int i = 0; i < 4; i++) load(8'(8'h30 + i), mk(29'(11 + i), CALL, 2'd0, 8'(8'h31 + i)));
        run = 1'b1;
        for (int i = 0; i < 4; i++) cyc("nest");
        chk("nest_err_before", 32'(stack_err), 32'd0);
        cyc("nest5");
        chk("ovf_err", 32'(stack_err), 32'd1);
        chk("ovf_upc", 32'(upc), 32'd0);
        chk("ovf_ctrl", 32'(ctrl), 32'd14);

        // RET on empty stack.
        do_reset();
        load(8'h00, mk(29'd4, RET, 2'd0, 8'h00));
        run = 1'b1;
        cyc("unf");
        chk("unf_err", 32'(stack_err), 32'd1);
        chk("unf_upc", 32'(upc), 32'd0);

        // Stall then HALT, then reset while halted.
        do_reset();
        load(8'h00, mk(29'h11, NEXT, 2'd0, 8'h00));
        load(8'h01, mk(29'h22, NEXT, 2'd0, 8'h00));
        load(8'h02, mk(29'h33, HALT, 2'd0, 8'h00));
        run = 1'b1;
        cyc("pre_stall");
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flags = 3'($urandom); opcode = 5'($urandom);
            cyc("stall");
            chk("stall_upc", 32'(upc), 32'd1);
            chk("stall_ctrl", 32'(ctrl), 32'd0);
        end
        run = 1'b1;
        cyc("post_stall");
        cyc("halt");
        chk("halt_ctrl", 32'(ctrl), 32'h33);
        chk("halt_flag", 32'(halted), 32'd1);
        cyc("halted");
        chk("halted_upc", 32'(upc), 32'd2);
        chk("halted_ctrl", 32'(ctrl), 32'd0);
        do_reset();
        chk("rst_upc", 32'(upc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Randomized program and stimulus.
        for (int a = 0; a < 256; a++) load(8'(a), rand_word());
        for (int i = 0; i < 2000; i++) begin
            run    = ($urandom_range(0, 9) != 0);
            flags  = 3'($urandom);
            opcode = 5'($urandom);
            ld_we  = ($urandom_range(0, 19) == 0);
            ld_addr = 8'($urandom);
            ld_data = rand_word();
            if ($urandom_range(0, 99) == 0 || (m_halt && $urandom_range(0, 4) == 0)) begin
                ld_we = 1'b0;
                do_reset();
            end else begin
                cyc("rand");
            end
        end
        ld_we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
